// File: rtl/sm_fetch.sv
// Instruction fetch stage: requests words from a variable-latency memory
// (one request outstanding), buffers them with their word addresses in a
// small prefetch FIFO and hands them to the core over valid/ready.
// A redirect flushes the FIFO and restarts fetch at a new word address.
module sm_fetch #(
    parameter int             FIFO_DEPTH = 4,
    parameter int             AW         = 32,
    parameter logic [AW-1:0]  RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          mem_req,
    output logic [AW-1:0]                 mem_addr,
    input  logic                          mem_ack,
    input  logic [31:0]                   mem_rdata,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [31:0]                   instr,
    output logic [AW-1:0]                 instr_pc,
    input  logic                          redirect,
    input  logic [AW-1:0]                 redirect_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // DRAIN means a request is in flight whose response belongs to a
    // path that has since been redirected away from.
    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   req_pc_reg, req_pc_next;
    logic [AW-1:0]   redir_pc_reg, redir_pc_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;

    logic [31:0]     data_mem [FIFO_DEPTH];
    logic [AW-1:0]   pc_mem   [FIFO_DEPTH];

    logic            room;
    logic            push;
    logic            pop;

    // Room is based on registered occupancy only, so instr_ready never
    // reaches mem_req combinationally. Since count only rises on an ack,
    // an issued request stays asserted until it is acknowledged.
    assign room     = (count_reg < CW'(FIFO_DEPTH));
    assign mem_req  = !rst && ((state_reg == DRAIN) || ((state_reg == RUN) && room));
    assign mem_addr = req_pc_reg;

    assign push = (state_reg == RUN) && room && mem_ack && !redirect;
    assign pop  = (count_reg != '0) && instr_ready && !redirect;

    assign instr_valid = (count_reg != '0);
    assign instr       = data_mem[rd_ptr_reg];
    assign instr_pc    = pc_mem[rd_ptr_reg];
    assign fifo_count  = count_reg;

    // Next-state: fetch FSM, fetch address and FIFO bookkeeping.
    always_comb begin
        state_next    = state_reg;
        req_pc_next   = req_pc_reg;
        redir_pc_next = redir_pc_reg;
        count_next    = count_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;

        if (redirect) begin
            // Flush everything; the only question is what to do with a
            // request that is still in flight.
            count_next  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            if (state_reg == RUN) begin
                if (mem_req && !mem_ack) begin
                    state_next    = DRAIN;
                    redir_pc_next = redirect_pc;
                end else begin
                    req_pc_next = redirect_pc;
                end
            end else begin
                if (mem_ack) begin
                    state_next  = RUN;
                    req_pc_next = redirect_pc;
                end else begin
                    redir_pc_next = redirect_pc;
                end
            end
        end else begin
            if (state_reg == RUN) begin
                if (push) begin
                    req_pc_next = req_pc_reg + AW'(1);
                end
            end else if (mem_ack) begin
                // Stale response dropped; resume at the saved target.
                state_next  = RUN;
                req_pc_next = redir_pc_reg;
            end

            if (push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            req_pc_reg   <= RESET_PC;
            redir_pc_reg <= RESET_PC;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            req_pc_reg   <= req_pc_next;
            redir_pc_reg <= redir_pc_next;
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
        end
    end

    // FIFO storage: word and its address written together on push.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            data_mem[wr_ptr_reg] <= mem_rdata;
            pc_mem[wr_ptr_reg]   <= req_pc_reg;
        end
    end

endmodule

// File: tb/tb_sm_fetch.sv
// Directed bench for sm_fetch: a vector table for steady fetch and
// FIFO-full behaviour, then hand-written redirect, wrap and reset sequences.
module tb_sm_fetch;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [2:0]    fifo_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sm_fetch #(
        .FIFO_DEPTH (4),
        .AW         (AW),
        .RESET_PC   ('0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fifo_count  (fifo_count)
    );

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] raddr;   // address whose word the memory returns
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs [15];

    // Memory content scheme: word at address a is a ^ C0DE0000.
    function automatic logic [31:0] dword(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Advance one clock, then drive this cycle's inputs and let them settle.
    task automatic cyc(input logic r, input logic ack, input logic [31:0] raddr,
                       input logic rdy, input logic rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst         = r;
        mem_ack     = ack;
        mem_rdata   = dword(raddr);
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic ex(input string tag, input logic req, input logic [31:0] addr,
                      input logic valid, input logic [31:0] pc, input logic [2:0] cnt);
        $display("%s: req=%0b addr=%h valid=%0b pc=%h cnt=%0d",
                 tag, mem_req, mem_addr, instr_valid, instr_pc, fifo_count);
        chk({tag, " mem_req"}, 32'(mem_req), 32'(req));
        chk({tag, " mem_addr"}, mem_addr, addr);
        chk({tag, " instr_valid"}, 32'(instr_valid), 32'(valid));
        chk({tag, " fifo_count"}, 32'(fifo_count), 32'(cnt));
        if (valid) begin
            chk({tag, " instr_pc"}, instr_pc, pc);
            chk({tag, " instr"}, instr, dword(pc));
        end
    endtask

    initial begin
        // rst ack raddr rdy redir rpc | req addr valid pc cnt
        // Steady fetch, memory acks the cycle after each request.
        vecs[0]  = '{1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 0, 1, 0, 0,  1, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 1, 0, 0,  1, 1, 1, 0, 1};
        vecs[4]  = '{0, 1, 1, 1, 0, 0,  1, 1, 0, 0, 0};
        vecs[5]  = '{0, 0, 0, 1, 0, 0,  1, 2, 1, 1, 1};
        vecs[6]  = '{0, 1, 2, 1, 0, 0,  1, 2, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 1, 0, 0,  1, 3, 1, 2, 1};
        // Consumer stalled, immediate acks: four pushes fill the FIFO.
        vecs[8]  = '{0, 1, 3, 0, 0, 0,  1, 3, 0, 0, 0};
        vecs[9]  = '{0, 1, 4, 0, 0, 0,  1, 4, 1, 3, 1};
        vecs[10] = '{0, 1, 5, 0, 0, 0,  1, 5, 1, 3, 2};
        vecs[11] = '{0, 1, 6, 0, 0, 0,  1, 6, 1, 3, 3};
        vecs[12] = '{0, 0, 0, 0, 0, 0,  0, 7, 1, 3, 4};
        // One pop while full; the request comes back the next cycle.
        vecs[13] = '{0, 0, 0, 1, 0, 0,  0, 7, 1, 3, 4};
        vecs[14] = '{0, 0, 0, 0, 0, 0,  1, 7, 1, 4, 3};

        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        @(posedge clk);
        @(posedge clk);

        for (int i = 0; i < 15; i++) begin
            cyc(vecs[i].rst, vecs[i].ack, vecs[i].raddr, vecs[i].ready,
                vecs[i].redir, vecs[i].rpc);
            ex($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
               vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_cnt);
        end

        // Redirect while a 3-cycle request is pending: response dropped.
        cyc(1, 0, 0, 1, 0, 0);
        chk("s3 rst mem_req", 32'(mem_req), 32'd0);
        cyc(0, 0, 0, 1, 0, 0);       ex("s3 c0", 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);       ex("s3 c1", 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);       ex("s3 c2", 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);       ex("s3 c3", 1, 1, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 0);       ex("s3 c4", 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0);       ex("s3 c5", 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 32'h40);  ex("s3 c6", 1, 2, 1, 1, 1);
        cyc(0, 0, 0, 1, 0, 0);       ex("s3 c7", 1, 2, 0, 0, 0);
        cyc(0, 1, 2, 1, 0, 0);       ex("s3 c8", 1, 2, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);       ex("s3 c9", 1, 32'h40, 0, 0, 0);
        cyc(0, 1, 32'h40, 1, 0, 0);  ex("s3 c10", 1, 32'h40, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);       ex("s3 c11", 1, 32'h41, 1, 32'h40, 1);

        // Redirect coinciding with ack and ready: no push, no pop.
        cyc(0, 1, 32'h41, 0, 0, 0);      ex("s4 c12", 1, 32'h41, 0, 0, 0);
        cyc(0, 1, 32'h42, 1, 1, 32'h80); ex("s4 c13", 1, 32'h42, 1, 32'h41, 1);
        cyc(0, 0, 0, 1, 0, 0);           ex("s4 c14", 1, 32'h80, 0, 0, 0);
        cyc(0, 1, 32'h80, 1, 0, 0);      ex("s4 c15", 1, 32'h80, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);           ex("s4 c16", 1, 32'h81, 1, 32'h80, 1);

        // Two redirects during one drain: the later target wins.
        cyc(0, 0, 0, 1, 1, 32'h10);      ex("s5 c17", 1, 32'h81, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 32'h20);      ex("s5 c18", 1, 32'h81, 0, 0, 0);
        cyc(0, 1, 32'h81, 1, 0, 0);      ex("s5 c19", 1, 32'h81, 0, 0, 0);
        cyc(0, 1, 32'h20, 1, 0, 0);      ex("s5 c20", 1, 32'h20, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);           ex("s5 c21", 1, 32'h21, 1, 32'h20, 1);

        // Address wrap at the top of the word space, then reset mid-request.
        cyc(0, 1, 32'h21, 1, 1, 32'hFFFF_FFFF); ex("s6 c22", 1, 32'h21, 0, 0, 0);
        cyc(0, 1, 32'hFFFF_FFFF, 1, 0, 0);      ex("s6 c23", 1, 32'hFFFF_FFFF, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);                  ex("s6 c24", 1, 32'h0, 1, 32'hFFFF_FFFF, 1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("s6 rst mem_req", 32'(mem_req), 32'd0);
        cyc(1, 0, 0, 0, 0, 0);                  ex("s6 c26", 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);                  ex("s6 c27", 1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
